dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Single-port memory arbiter shared by the instruction fetch and MEM stages.
// A data access wins over a fetch in the same cycle. A store completes in the
// cycle it issues. A load or fetch waits LAT cycles for mem_rdata.
// Served flags stop a stalled pipeline from issuing the same access twice.
module dmem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  input  logic            dm_read,
  input  logic            dm_write,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wstrb,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_stall,
  input  logic            pipe_adv,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DM_WAIT = 2'd1;
  localparam logic [1:0] IF_WAIT = 2'd2;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          dm_served;
  logic          if_served;
  logic [DW-1:0] dm_hold;
  logic [DW-1:0] if_hold;

  logic dm_pend;
  logic if_pend;
  logic issue_dm;
  logic issue_if;
  logic store_done;
  logic dm_done;
  logic if_done;

  // Request decode and completion detection; reset_n gates everything so all outputs read 0 in reset
  always_comb begin
    dm_pend    = reset_n & (dm_read | dm_write) & ~dm_served;
    if_pend    = reset_n & if_req & ~if_served;
    issue_dm   = (state == IDLE) & dm_pend;
    issue_if   = (state == IDLE) & ~dm_pend & if_pend;
    store_done = issue_dm & dm_write;
    dm_done    = reset_n & (state == DM_WAIT) & (cnt == LAT_CNT);
    if_done    = reset_n & (state == IF_WAIT) & (cnt == LAT_CNT);
  end

  // Memory command, stall and read-data outputs
  always_comb begin
    mem_en    = issue_dm | issue_if;
    mem_we    = store_done;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (issue_dm) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_wstrb = dm_wstrb;
    end else if (issue_if) begin
      mem_addr  = if_addr;
    end
    dm_stall = dm_pend & ~store_done & ~dm_done;
    if_stall = if_pend & ~if_done;
    dm_rdata = dm_done ? mem_rdata : dm_hold;
    if_rdata = if_done ? mem_rdata : if_hold;
  end

  // FSM, latency counter, served flags and read-data hold registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dm_served <= 1'b0;
      if_served <= 1'b0;
      dm_hold   <= '0;
      if_hold   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_dm && !dm_write) begin
            state <= DM_WAIT;
            cnt   <= 4'd1;
          end else if (issue_if) begin
            state <= IF_WAIT;
            cnt   <= 4'd1;
          end
        end
        DM_WAIT, IF_WAIT: begin
          if (dm_done || if_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (dm_done) dm_hold <= mem_rdata;
      if (if_done) if_hold <= mem_rdata;

      if (pipe_adv) begin
        dm_served <= 1'b0;
        if_served <= 1'b0;
      end else begin
        if (store_done || dm_done) dm_served <= 1'b1;
        if (if_done)               if_served <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle table on a LAT=2 instance,
// then hand-written reset-abort and LAT=1 back-to-back sequences.
module tb_dmem_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        rd;
    logic        wr;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        adv;
    logic [31:0] mrd;
    logic        e_ifs;
    logic        e_dms;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_ma;
    logic [31:0] e_mwd;
    logic [3:0]  e_mws;
    logic [31:0] e_ifrd;
    logic [31:0] e_dmrd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_read = 1'b0;
  logic        dm_write = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_wstrb = '0;
  logic        pipe_adv = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] l1_mem_rdata = '0;

  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_stall, dm_stall, mem_en, mem_we;
  logic [3:0]  mem_wstrb;

  logic [31:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l1_if_stall, l1_dm_stall, l1_mem_en, l1_mem_we;
  logic [3:0]  l1_mem_wstrb;

  int checks = 0;
  int passed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .LAT(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .pipe_adv(pipe_adv),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.AW(32), .DW(32), .LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(l1_if_rdata), .if_stall(l1_if_stall),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_rdata(l1_dm_rdata), .dm_stall(l1_dm_stall),
    .pipe_adv(pipe_adv),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_wstrb(l1_mem_wstrb), .mem_rdata(l1_mem_rdata)
  );

  function automatic vec_t mk(
    input logic ifr, input logic [31:0] ifa, input logic rd, input logic wr,
    input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws,
    input logic adv, input logic [31:0] mrd,
    input logic ifs, input logic dms, input logic en, input logic we,
    input logic [31:0] ma, input logic [31:0] mwd, input logic [3:0] mws,
    input logic [31:0] ifrd, input logic [31:0] dmrd);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.rd = rd; v.wr = wr; v.da = da; v.wd = wd;
    v.ws = ws; v.adv = adv; v.mrd = mrd;
    v.e_ifs = ifs; v.e_dms = dms; v.e_en = en; v.e_we = we; v.e_ma = ma;
    v.e_mwd = mwd; v.e_mws = mws; v.e_ifrd = ifrd; v.e_dmrd = dmrd;
    return v;
  endfunction

  task automatic check_output(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    else
      passed++;
  endtask

  task automatic apply_stimulus(input vec_t v);
    if_req   = v.ifr;  if_addr  = v.ifa;
    dm_read  = v.rd;   dm_write = v.wr;  dm_addr = v.da;
    dm_wdata = v.wd;   dm_wstrb = v.ws;
    pipe_adv = v.adv;  mem_rdata = v.mrd;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    check_output("if_stall",  idx, 32'(if_stall),  32'(v.e_ifs));
    check_output("dm_stall",  idx, 32'(dm_stall),  32'(v.e_dms));
    check_output("mem_en",    idx, 32'(mem_en),    32'(v.e_en));
    check_output("mem_we",    idx, 32'(mem_we),    32'(v.e_we));
    check_output("mem_addr",  idx, mem_addr,       v.e_ma);
    check_output("mem_wdata", idx, mem_wdata,      v.e_mwd);
    check_output("mem_wstrb", idx, 32'(mem_wstrb), 32'(v.e_mws));
    check_output("if_rdata",  idx, if_rdata,       v.e_ifrd);
    check_output("dm_rdata",  idx, dm_rdata,       v.e_dmrd);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    // Cycle table for the LAT=2 instance, starting just after reset release
    vecs.push_back(mk(0,0,0,0,0,0,0,0,JUNK,                 0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,'h100,0,0,0,JUNK,             0,1,1,0,'h100,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,'h100,0,0,0,JUNK,             0,1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,'h100,0,0,1,'hDEADBEEF,       0,0,0,0,0,0,0,0,'hDEADBEEF));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,JUNK,                 0,0,0,0,0,0,0,0,'hDEADBEEF));
    vecs.push_back(mk(0,0,0,1,'h40,'h12345678,'hF,1,JUNK,   0,0,1,1,'h40,'h12345678,'hF,0,'hDEADBEEF));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,JUNK,                 0,0,0,0,0,0,0,0,'hDEADBEEF));
    vecs.push_back(mk(0,0,1,1,'h44,'hCAFEF00D,'h3,1,JUNK,   0,0,1,1,'h44,'hCAFEF00D,'h3,0,'hDEADBEEF));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,0,JUNK,    1,1,1,0,'h104,'h55,'hF,0,'hDEADBEEF));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,0,JUNK,    1,1,0,0,0,0,0,0,'hDEADBEEF));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,0,'hAAAA0001, 1,0,0,0,0,0,0,0,'hAAAA0001));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,0,JUNK,    1,0,1,0,'h200,0,0,0,'hAAAA0001));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,0,JUNK,    1,0,0,0,0,0,0,0,'hAAAA0001));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,0,'hBBBB0002, 0,0,0,0,0,0,0,'hBBBB0002,'hAAAA0001));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,0,JUNK,    0,0,0,0,0,0,0,'hBBBB0002,'hAAAA0001));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,1,JUNK,    0,0,0,0,0,0,0,'hBBBB0002,'hAAAA0001));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,0,JUNK,    1,1,1,0,'h104,'h55,'hF,'hBBBB0002,'hAAAA0001));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,0,JUNK,    1,1,0,0,0,0,0,'hBBBB0002,'hAAAA0001));
    vecs.push_back(mk(1,'h200,1,0,'h104,'h55,'hF,1,'hCCCC0003, 1,0,0,0,0,0,0,'hBBBB0002,'hCCCC0003));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,JUNK,                 0,0,0,0,0,0,0,'hBBBB0002,'hCCCC0003));
    idle = mk(0,0,0,0,0,0,0,0,JUNK, 0,0,0,0,0,0,0,0,0);

    // Reset state: outputs must be 0 even with requests driven
    reset_n = 1'b0;
    if_req = 1'b1; if_addr = 'h80; dm_read = 1'b1; dm_addr = 'h90;
    dm_wdata = 'h77; dm_wstrb = 'hF; mem_rdata = JUNK;
    next_cycle();
    next_cycle();
    check_vec(idle, -1);
    apply_stimulus(idle);
    reset_n = 1'b1;

    // Table-driven portion
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_vec(vecs[i], i);
      next_cycle();
    end

    // Reset during an in-flight load: outputs drop at once, late data ignored
    dm_read = 1'b1; dm_addr = 'h300; dm_wdata = '0; dm_wstrb = '0; pipe_adv = 1'b0;
    mem_rdata = JUNK;
    @(negedge clk);
    check_output("rst_issue_en", 100, 32'(mem_en), 32'd1);
    next_cycle();
    reset_n = 1'b0;
    #1;
    check_vec(idle, 101);
    next_cycle();
    reset_n = 1'b1;
    dm_read = 1'b0;
    mem_rdata = 'hDEADBEEF;
    @(negedge clk);
    check_vec(idle, 102);
    next_cycle();
    @(negedge clk);
    check_vec(idle, 103);
    next_cycle();

    // LAT=1 instance: held load with pipe_adv=1 reissues every second cycle
    dm_read = 1'b1; dm_addr = 'h10; pipe_adv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      l1_mem_rdata = 32'h1000 + 32'(k);
      @(negedge clk);
      if (k % 2 == 0) begin
        check_output("l1_dm_en",    200 + k, 32'(l1_mem_en),   32'd1);
        check_output("l1_dm_addr",  200 + k, l1_mem_addr,      32'h10);
        check_output("l1_dm_stall", 200 + k, 32'(l1_dm_stall), 32'd1);
      end else begin
        check_output("l1_dm_en",    200 + k, 32'(l1_mem_en),   32'd0);
        check_output("l1_dm_stall", 200 + k, 32'(l1_dm_stall), 32'd0);
        check_output("l1_dm_rdata", 200 + k, l1_dm_rdata,      32'h1000 + 32'(k));
      end
      next_cycle();
    end

    // LAT=1 instance: held fetch follows the same two-cycle rhythm
    dm_read = 1'b0; if_req = 1'b1; if_addr = 'h20;
    for (int k = 0; k < 4; k++) begin
      l1_mem_rdata = 32'h2000 + 32'(k);
      @(negedge clk);
      if (k % 2 == 0) begin
        check_output("l1_if_en",    300 + k, 32'(l1_mem_en),   32'd1);
        check_output("l1_if_addr",  300 + k, l1_mem_addr,      32'h20);
        check_output("l1_if_wstrb", 300 + k, 32'(l1_mem_wstrb), 32'd0);
        check_output("l1_if_stall", 300 + k, 32'(l1_if_stall), 32'd1);
      end else begin
        check_output("l1_if_en",    300 + k, 32'(l1_mem_en),   32'd0);
        check_output("l1_if_stall", 300 + k, 32'(l1_if_stall), 32'd0);
        check_output("l1_if_rdata", 300 + k, l1_if_rdata,      32'h2000 + 32'(k));
      end
      next_cycle();
    end
    if_req = 1'b0; pipe_adv = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
